avalon_io12_switch_ctrl: RTL and testbench

AVALON_IO12_SWITCH_CTRL -- requirements
Module: avalon_io12_switch_ctrl

---
 rtl/avalon_io12_switch_ctrl.sv | 156 +++++++++++++++
 tb/tb_avalon_io12_switch_ctrl.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/avalon_io12_switch_ctrl.sv
// Channel-select controller for a 4:1 streaming switcher: drains the old source,
// blanks downstream while the mux settles, and handles scan rotation and error failover.
module avalon_io12_switch_ctrl #(
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter int unsigned DRAIN_TIMEOUT = 64,
  parameter int unsigned ERR_LIMIT     = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  req_select,
  input  logic        req_strobe,
  input  logic        scan_enable,
  input  logic [15:0] dwell_count,
  input  logic        failover_enable,
  input  logic        mon_valid,
  input  logic [1:0]  mon_error,
  output logic [1:0]  select,
  output logic        blank,
  output logic        busy,
  output logic        switch_done,
  output logic        failover_event
);

  typedef enum logic [1:0] {RUN, DRAIN, SETTLE} state_t;

  state_t      state, state_n;
  logic [1:0]  sel_q, sel_n, tgt_q, tgt_n, pend_sel_q, pend_sel_n;
  logic        pend_q, pend_n;
  logic [3:0]  settle_q, settle_n, err_q, err_n;
  logic [7:0]  drain_q, drain_n;
  logic [15:0] dwell_q, dwell_n;
  logic        done_q, done_n, fo_q, fo_n;

  logic        req_vld, scan_on, scan_hit, fo_hit;
  logic [1:0]  req_sel;

  // A live strobe is newer than anything parked in the pending slot.
  always_comb begin
    req_vld = pend_q;
    req_sel = pend_sel_q;
    if (req_strobe) begin
      req_vld = 1'b1;
      req_sel = req_select;
    end
  end

  assign scan_on  = scan_enable && (dwell_count != 16'd0);
  assign scan_hit = scan_on && (dwell_q >= dwell_count - 16'd1);
  assign fo_hit   = failover_enable && (err_q == 4'(ERR_LIMIT));

  always_comb begin
    state_n    = state;
    sel_n      = sel_q;
    tgt_n      = tgt_q;
    pend_n     = pend_q;
    pend_sel_n = pend_sel_q;
    settle_n   = settle_q;
    drain_n    = drain_q;
    dwell_n    = dwell_q;
    err_n      = err_q;
    done_n     = 1'b0;
    fo_n       = 1'b0;
    case (state)
      RUN: begin
        pend_n  = 1'b0;
        dwell_n = scan_on ? dwell_q + 16'd1 : 16'd0;
        if (mon_valid) begin
          if (mon_error != 2'd0) begin
            if (err_q != 4'(ERR_LIMIT)) err_n = err_q + 4'd1;
          end else begin
            err_n = 4'd0;
          end
        end
        if (req_vld && (req_sel != sel_q)) begin
          tgt_n   = req_sel;
          state_n = DRAIN;
        end else if (fo_hit) begin
          fo_n    = 1'b1;
          tgt_n   = sel_q + 2'd1;
          state_n = DRAIN;
        end else if (scan_hit) begin
          tgt_n   = sel_q + 2'd1;
          state_n = DRAIN;
        end
        if (state_n == DRAIN) drain_n = 8'd0;
      end
      DRAIN: begin
        if (req_strobe) begin
          pend_n     = 1'b1;
          pend_sel_n = req_select;
        end
        if (!mon_valid || (drain_q == 8'(DRAIN_TIMEOUT - 1))) begin
          sel_n    = tgt_q;
          settle_n = 4'(SETTLE_CYCLES);
          state_n  = SETTLE;
        end else begin
          drain_n = drain_q + 8'd1;
        end
      end
      SETTLE: begin
        if (req_strobe) begin
          pend_n     = 1'b1;
          pend_sel_n = req_select;
        end
        if (settle_q <= 4'd1) begin
          state_n = RUN;
          done_n  = 1'b1;
          dwell_n = 16'd0;
          err_n   = 4'd0;
        end else begin
          settle_n = settle_q - 4'd1;
        end
      end
      default: begin
        state_n  = SETTLE;
        settle_n = 4'(SETTLE_CYCLES);
      end
    endcase
  end

  // Reset parks the block in a full SETTLE so downstream is blanked from power-up.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= SETTLE;
      sel_q      <= 2'd0;
      tgt_q      <= 2'd0;
      pend_q     <= 1'b0;
      pend_sel_q <= 2'd0;
      settle_q   <= 4'(SETTLE_CYCLES);
      drain_q    <= 8'd0;
      dwell_q    <= 16'd0;
      err_q      <= 4'd0;
      done_q     <= 1'b0;
      fo_q       <= 1'b0;
    end else begin
      state      <= state_n;
      sel_q      <= sel_n;
      tgt_q      <= tgt_n;
      pend_q     <= pend_n;
      pend_sel_q <= pend_sel_n;
      settle_q   <= settle_n;
      drain_q    <= drain_n;
      dwell_q    <= dwell_n;
      err_q      <= err_n;
      done_q     <= done_n;
      fo_q       <= fo_n;
    end
  end

  assign select         = sel_q;
  assign blank          = (state == SETTLE);
  assign busy           = (state != RUN);
  assign switch_done    = done_q;
  assign failover_event = fo_q;

endmodule

// File: tb/tb_avalon_io12_switch_ctrl.sv
// Directed bench for avalon_io12_switch_ctrl: reset, idle/timeout drains, scan wrap,
// failover, coincident triggers, pending requests and reset mid-DRAIN.
module tb_avalon_io12_switch_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  req_select;
  logic        req_strobe;
  logic        scan_enable;
  logic [15:0] dwell_count;
  logic        failover_enable;
  logic        mon_valid;
  logic [1:0]  mon_error;
  logic [1:0]  select;
  logic        blank, busy, switch_done, failover_event;

  int ncmp = 0;
  int nerr = 0;

  avalon_io12_switch_ctrl dut (
    .clk(clk), .reset(reset), .req_select(req_select), .req_strobe(req_strobe),
    .scan_enable(scan_enable), .dwell_count(dwell_count),
    .failover_enable(failover_enable), .mon_valid(mon_valid), .mon_error(mon_error),
    .select(select), .blank(blank), .busy(busy), .switch_done(switch_done),
    .failover_event(failover_event)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic strobe(input logic [1:0] s);
    req_select = s;
    req_strobe = 1'b1;
    tick(1);
    req_strobe = 1'b0;
  endtask

  task automatic sample(input logic v, input logic [1:0] e);
    mon_valid = v;
    mon_error = e;
    tick(1);
  endtask

  // Idle-monitor switch: lands on the first RUN cycle (switch_done high).
  task automatic do_switch(input logic [1:0] s);
    mon_valid = 1'b0;
    strobe(s);
    tick(3);
    chk("sw_sel", 32'(select), 32'(s));
    chk("sw_done", 32'(switch_done), 32'd1);
  endtask

  initial begin
    reset = 1'b1; req_select = 2'd0; req_strobe = 1'b0; scan_enable = 1'b0;
    dwell_count = 16'd0; failover_enable = 1'b0; mon_valid = 1'b0; mon_error = 2'd0;

    tick(2);
    chk("rst_sel", 32'(select), 32'd0);
    chk("rst_blank", 32'(blank), 32'd1);
    chk("rst_busy", 32'(busy), 32'd1);
    chk("rst_done", 32'(switch_done), 32'd0);
    chk("rst_fo", 32'(failover_event), 32'd0);

    reset = 1'b0;
    tick(1);
    chk("rel_blank1", 32'(blank), 32'd1);
    chk("rel_done0", 32'(switch_done), 32'd0);
    tick(1);
    chk("rel_blank0", 32'(blank), 32'd0);
    chk("rel_done", 32'(switch_done), 32'd1);
    chk("rel_busy", 32'(busy), 32'd0);
    chk("rel_sel", 32'(select), 32'd0);
    tick(1);
    chk("rel_done_once", 32'(switch_done), 32'd0);

    // Drain timeout: monitor stays valid, 64 DRAIN cycles before the select moves.
    mon_valid = 1'b1;
    strobe(2'd1);
    chk("to_busy", 32'(busy), 32'd1);
    tick(63);
    chk("to_sel_hold", 32'(select), 32'd0);
    chk("to_blank_hold", 32'(blank), 32'd0);
    tick(1);
    chk("to_sel", 32'(select), 32'd1);
    chk("to_blank", 32'(blank), 32'd1);
    mon_valid = 1'b0;
    tick(2);
    chk("to_done", 32'(switch_done), 32'd1);

    // Idle-monitor switch to 2 with step-by-step timing.
    strobe(2'd2);
    chk("idle_drain", 32'(busy), 32'd1);
    chk("idle_sel_old", 32'(select), 32'd1);
    chk("idle_blank_drain", 32'(blank), 32'd0);
    tick(1);
    chk("idle_sel", 32'(select), 32'd2);
    chk("idle_blank_a", 32'(blank), 32'd1);
    tick(1);
    chk("idle_blank_b", 32'(blank), 32'd1);
    tick(1);
    chk("idle_blank_c", 32'(blank), 32'd0);
    chk("idle_done", 32'(switch_done), 32'd1);
    chk("idle_busy", 32'(busy), 32'd0);
    tick(1);
    chk("idle_done_off", 32'(switch_done), 32'd0);

    // Strobe to the current channel is a no-op.
    strobe(2'd2);
    chk("noop_busy", 32'(busy), 32'd0);
    tick(2);
    chk("noop_done", 32'(switch_done), 32'd0);
    chk("noop_sel", 32'(select), 32'd2);

    // Scan from 3 wraps to 0, then 1, 2, 3, 0 every 13 cycles.
    do_switch(2'd3);
    scan_enable = 1'b1;
    dwell_count = 16'd10;
    tick(9);
    chk("scan_run9", 32'(busy), 32'd0);
    tick(1);
    chk("scan_drain", 32'(busy), 32'd1);
    chk("scan_sel_hold", 32'(select), 32'd3);
    tick(1);
    chk("scan_wrap0", 32'(select), 32'd0);
    tick(13);
    chk("scan_1", 32'(select), 32'd1);
    tick(13);
    chk("scan_2", 32'(select), 32'd2);
    tick(13);
    chk("scan_3", 32'(select), 32'd3);
    tick(13);
    chk("scan_0", 32'(select), 32'd0);
    scan_enable = 1'b0;
    tick(2);
    chk("scan_off_done", 32'(switch_done), 32'd1);

    // Clean sample in the middle of errors resets the count: no failover.
    do_switch(2'd1);
    failover_enable = 1'b1;
    sample(1'b1, 2'b01); sample(1'b1, 2'b01); sample(1'b1, 2'b01);
    sample(1'b1, 2'b00);
    sample(1'b1, 2'b01); sample(1'b1, 2'b01); sample(1'b1, 2'b01);
    sample(1'b0, 2'b00);
    sample(1'b0, 2'b00);
    chk("clean_busy", 32'(busy), 32'd0);
    chk("clean_fo", 32'(failover_event), 32'd0);
    chk("clean_sel", 32'(select), 32'd1);

    // Fourth error arms failover; a strobe in the same cycle wins with its own target.
    sample(1'b1, 2'b01);
    mon_valid = 1'b0;
    mon_error = 2'b00;
    strobe(2'd3);
    chk("coin_fo", 32'(failover_event), 32'd0);
    chk("coin_busy", 32'(busy), 32'd1);
    tick(1);
    chk("coin_sel", 32'(select), 32'd3);
    tick(2);
    chk("coin_done", 32'(switch_done), 32'd1);

    // Failover proper: four errored valid samples with one idle gap.
    do_switch(2'd1);
    sample(1'b1, 2'b01); sample(1'b1, 2'b01);
    sample(1'b0, 2'b00);
    sample(1'b1, 2'b01); sample(1'b1, 2'b01);
    mon_valid = 1'b0;
    mon_error = 2'b00;
    chk("fo_pre", 32'(failover_event), 32'd0);
    tick(1);
    chk("fo_pulse", 32'(failover_event), 32'd1);
    chk("fo_busy", 32'(busy), 32'd1);
    chk("fo_sel_hold", 32'(select), 32'd1);
    tick(1);
    chk("fo_pulse_off", 32'(failover_event), 32'd0);
    chk("fo_sel", 32'(select), 32'd2);
    tick(2);
    chk("fo_done", 32'(switch_done), 32'd1);

    // Strobe during SETTLE is pended and serviced right after switch_done.
    strobe(2'd3);
    tick(1);
    chk("pend_sel3", 32'(select), 32'd3);
    chk("pend_settle", 32'(blank), 32'd1);
    strobe(2'd1);
    tick(1);
    chk("pend_done", 32'(switch_done), 32'd1);
    chk("pend_sel_still3", 32'(select), 32'd3);
    tick(1);
    chk("pend_drain", 32'(busy), 32'd1);
    chk("pend_blank", 32'(blank), 32'd0);
    tick(1);
    chk("pend_sel1", 32'(select), 32'd1);
    tick(2);
    chk("pend_done2", 32'(switch_done), 32'd1);

    // Reset in the middle of a DRAIN.
    mon_valid = 1'b1;
    strobe(2'd2);
    tick(3);
    chk("mid_busy", 32'(busy), 32'd1);
    chk("mid_sel", 32'(select), 32'd1);
    reset = 1'b1;
    #1;
    chk("mid_rst_sel", 32'(select), 32'd0);
    chk("mid_rst_blank", 32'(blank), 32'd1);
    chk("mid_rst_busy", 32'(busy), 32'd1);
    chk("mid_rst_done", 32'(switch_done), 32'd0);
    tick(1);
    reset = 1'b0;
    mon_valid = 1'b0;
    tick(1);
    chk("mid_rel_blank", 32'(blank), 32'd1);
    tick(1);
    chk("mid_rel_done", 32'(switch_done), 32'd1);
    chk("mid_rel_sel", 32'(select), 32'd0);
    chk("mid_rel_busy", 32'(busy), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
